// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and instruction-fetch front end feeding IF/ID.
// Define FETCH_HALT_EN to enable the HALT stop on opcode 4'hF.
module fetch_stage #(
  parameter int PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [19:0]         imem_data,
  output logic [19:0]         instruction,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                valid,
  output logic [15:0]         fetch_count
);
`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
  typedef enum logic {BOOT, RUN} state_t;
`endif
  state_t state;
  logic [PC_WIDTH-1:0] pc;
  logic accept;
  // A redirect squashes whatever is being fetched this cycle.
  assign valid = state == RUN && !redirect;
  assign instruction = valid ? imem_data : 20'h00000;
  assign accept = valid && !stall;
  assign imem_addr = pc;
  assign pc_out = pc;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      state <= BOOT;
      fetch_count <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
      state <= RUN;
    end else if (state == BOOT && !stall) begin
      state <= RUN;
    end else if (accept) begin
      pc <= pc + 1'b1;
      fetch_count <= fetch_count + 16'd1;
`ifdef FETCH_HALT_EN
      if (imem_data[19:16] == 4'hF) state <= HALT;
`endif
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of boot, stall, redirect, wrap, HALT and async reset.
module tb_fetch_stage;
  logic clock = 0, reset = 1, stall = 0, redirect = 0;
  logic [7:0] redirect_pc = 0, imem_addr, pc_out;
  logic [19:0] imem_data, instruction;
  logic valid;
  logic [15:0] fetch_count;
  logic [19:0] mem [256];
  int n_checks = 0, n_errors = 0;

  fetch_stage #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .pc_out(pc_out), .valid(valid), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;
  assign imem_data = mem[imem_addr];

  function automatic logic [19:0] ev(input logic [7:0] a);
    return {4'h2, 8'h00, a};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    chk("rst_valid", 20'(valid), 20'd0);
    chk("rst_instr", instruction, 20'h0);
    chk("rst_pc", 20'(pc_out), 20'h0);
    chk("rst_addr", 20'(imem_addr), 20'h0);
    chk("rst_count", 20'(fetch_count), 20'h0);
    @(posedge clock);
    #1 reset = 0;
    #1;
    chk("boot_valid", 20'(valid), 20'd0);
    chk("boot_instr", instruction, 20'h0);
    tick();
    chk("first_valid", 20'(valid), 20'd1);
    chk("first_instr", instruction, 20'h12340);
    chk("first_pc", 20'(pc_out), 20'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("step_pc", 20'(pc_out), 20'(i));
      chk("step_instr", instruction, ev(8'(i)));
      chk("step_count", 20'(fetch_count), 20'(i));
    end
  endtask

  task automatic test_stall();
    tick();
    tick();
    chk("pre_stall_pc", 20'(pc_out), 20'h5);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pc", 20'(pc_out), 20'h5);
      chk("stall_instr", instruction, ev(8'h05));
      chk("stall_valid", 20'(valid), 20'd1);
      chk("stall_count", 20'(fetch_count), 20'd5);
      tick();
    end
    stall = 0;
    #1;
    chk("release_pc", 20'(pc_out), 20'h5);
    tick();
    chk("after_stall_pc", 20'(pc_out), 20'h6);
    chk("after_stall_count", 20'(fetch_count), 20'd6);
  endtask

  task automatic test_redirect_stall();
    redirect = 1; redirect_pc = 8'h03;
    #1;
    chk("redir_squash_valid", 20'(valid), 20'd0);
    chk("redir_squash_instr", instruction, 20'h0);
    tick();
    redirect = 0;
    #1;
    chk("redir_pc3", 20'(pc_out), 20'h3);
    chk("redir_count", 20'(fetch_count), 20'd6);
    redirect = 1; redirect_pc = 8'h40; stall = 1;
    #1;
    chk("redir_stall_valid", 20'(valid), 20'd0);
    chk("redir_stall_instr", instruction, 20'h0);
    tick();
    redirect = 0; stall = 0;
    #1;
    chk("redir_tgt_pc", 20'(pc_out), 20'h40);
    chk("redir_tgt_valid", 20'(valid), 20'd1);
    chk("redir_tgt_instr", instruction, ev(8'h40));
    chk("redir_tgt_count", 20'(fetch_count), 20'd6);
  endtask

  task automatic test_back_to_back();
    redirect = 1; redirect_pc = 8'h80;
    tick();
    redirect_pc = 8'h90;
    #1;
    chk("b2b_bubble", 20'(valid), 20'd0);
    tick();
    redirect = 0;
    #1;
    chk("b2b_pc", 20'(pc_out), 20'h90);
    chk("b2b_valid", 20'(valid), 20'd1);
    redirect = 1;
    #1;
    chk("same_bubble", 20'(valid), 20'd0);
    tick();
    redirect = 0;
    #1;
    chk("same_pc", 20'(pc_out), 20'h90);
    chk("same_instr", instruction, ev(8'h90));
    chk("same_count", 20'(fetch_count), 20'd6);
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_pc = 8'hFE;
    tick();
    redirect = 0;
    #1;
    chk("wrap_fe", 20'(pc_out), 20'hFE);
    tick();
    chk("wrap_ff", 20'(pc_out), 20'hFF);
    tick();
    chk("wrap_00", 20'(pc_out), 20'h00);
    chk("wrap_instr", instruction, 20'h12340);
    tick();
    chk("wrap_01", 20'(pc_out), 20'h01);
    chk("wrap_count", 20'(fetch_count), 20'd9);
  endtask

  task automatic test_halt();
    mem[2] = 20'hF0000;
    redirect = 1; redirect_pc = 8'h00;
    tick();
    redirect = 0;
    tick();
    tick();
    chk("halt_pc", 20'(pc_out), 20'h2);
    chk("halt_valid", 20'(valid), 20'd1);
    chk("halt_instr", instruction, 20'hF0000);
    tick();
    chk("post_halt_pc", 20'(pc_out), 20'h3);
    chk("post_halt_count", 20'(fetch_count), 20'd12);
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 10; i++) begin
      chk("halted_valid", 20'(valid), 20'd0);
      chk("halted_instr", instruction, 20'h0);
      chk("halted_pc", 20'(pc_out), 20'h3);
      tick();
    end
    chk("halted_count", 20'(fetch_count), 20'd12);
`else
    chk("nohalt_valid", 20'(valid), 20'd1);
    chk("nohalt_instr", instruction, ev(8'h03));
`endif
    redirect = 1; redirect_pc = 8'h00;
    tick();
    redirect = 0;
    #1;
    chk("resume_pc", 20'(pc_out), 20'h0);
    chk("resume_valid", 20'(valid), 20'd1);
    chk("resume_count", 20'(fetch_count), 20'd12);
    mem[2] = ev(8'h02);
  endtask

  task automatic test_async_reset();
    redirect = 1; redirect_pc = 8'h09;
    tick();
    redirect = 0; stall = 1;
    tick();
    chk("pre_rst_pc", 20'(pc_out), 20'h9);
    #2 reset = 1;
    #1;
    chk("async_pc", 20'(pc_out), 20'h0);
    chk("async_valid", 20'(valid), 20'd0);
    chk("async_count", 20'(fetch_count), 20'd0);
    chk("async_instr", instruction, 20'h0);
    stall = 0;
    @(posedge clock);
    #1 reset = 0;
    tick();
    chk("reboot_valid", 20'(valid), 20'd1);
    chk("reboot_instr", instruction, 20'h12340);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = ev(8'(i));
    mem[0] = 20'h12340;
    test_reset();
    test_stall();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
